// File: rtl/stream_demux.sv
// One-input, two-output stream demultiplexer with a one-entry register per channel
// and per-channel delivery counters.
module stream_demux #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_data,
    input  logic          in_select,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out0_data,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [N-1:0]  out1_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    input  logic          clear,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e          st0_q, st0_d, st1_q, st1_d;
    logic [N-1:0]   data0_q, data0_d, data1_q, data1_d;
    logic [CW-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic           accept, load0, load1, deliv0, deliv1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st0_q   <= EMPTY;
            st1_q   <= EMPTY;
            data0_q <= '0;
            data1_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            st0_q   <= st0_d;
            st1_q   <= st1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    // A load into a channel being drained in the same cycle keeps it FULL (no bubble).
    always_comb begin
        accept  = in_valid && in_ready;
        load0   = accept && !in_select;
        load1   = accept && in_select;
        deliv0  = (st0_q == FULL) && out0_ready;
        deliv1  = (st1_q == FULL) && out1_ready;

        st0_d = st0_q;
        if (load0)       st0_d = FULL;
        else if (deliv0) st0_d = EMPTY;

        st1_d = st1_q;
        if (load1)       st1_d = FULL;
        else if (deliv1) st1_d = EMPTY;

        data0_d = load0 ? in_data : data0_q;
        data1_d = load1 ? in_data : data1_q;

        cnt0_d = clear ? '0 : cnt0_q + CW'(deliv0);
        cnt1_d = clear ? '0 : cnt1_q + CW'(deliv1);
    end

    always_comb begin
        out0_valid = (st0_q == FULL);
        out1_valid = (st1_q == FULL);
        out0_data  = data0_q;
        out1_data  = data1_q;
        cnt0       = cnt0_q;
        cnt1       = cnt1_q;
        in_ready   = in_select ? (!out1_valid || out1_ready)
                               : (!out0_valid || out0_ready);
    end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: directed scenarios plus a random run,
// with per-channel expected-word queues and a reference delivery-counter model.
module tb_stream_demux;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  in_data = '0;
    logic          in_select = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  out0_data, out1_data;
    logic          out0_valid, out1_valid;
    logic          out0_ready = 1'b0;
    logic          out1_ready = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] cnt0, cnt1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [N-1:0]  q0[$];
    logic [N-1:0]  q1[$];
    logic [CW-1:0] mc0 = '0;
    logic [CW-1:0] mc1 = '0;

    stream_demux #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_select  (in_select),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .clear      (clear),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [N-1:0] d);
        in_valid  = v;
        in_select = s;
        in_data   = d;
    endtask

    // Stimulus side: record every word the DUT accepted, after the monitor has run.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && in_valid && in_ready) begin
            if (in_select) q1.push_back(in_data);
            else           q0.push_back(in_data);
        end
    end

    // Monitor: every delivery must match the head of its channel queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            mc0 = '0;
            mc1 = '0;
        end else begin
            check("cnt0_model", cnt0, mc0);
            check("cnt1_model", cnt1, mc1);
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) check("ch0_spurious", 1, 0);
                else                check("ch0_data", out0_data, q0.pop_front());
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) check("ch1_spurious", 1, 0);
                else                check("ch1_data", out1_data, q1.pop_front());
            end
            mc0 = clear ? '0 : mc0 + CW'(out0_valid && out0_ready);
            mc1 = clear ? '0 : mc1 + CW'(out1_valid && out1_ready);
        end
    end

    initial begin
        // Reset
        cyc();
        cyc();
        check("rst_v0", out0_valid, 0);
        check("rst_v1", out1_valid, 0);
        check("rst_d0", out0_data, 0);
        check("rst_d1", out1_data, 0);
        check("rst_c0", cnt0, 0);
        check("rst_c1", cnt1, 0);
        check("rst_rdy", in_ready, 1);
        rst_n = 1'b1;

        // Basic route to channel 0
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1, 0, 4'hA);
        cyc();
        drive(0, 0, 4'h0);
        #1;
        check("r_v0", out0_valid, 1);
        check("r_d0", out0_data, 4'hA);
        check("r_v1", out1_valid, 0);
        cyc();
        check("r_v0_after", out0_valid, 0);
        check("r_cnt0", cnt0, 1);
        check("r_hold_d0", out0_data, 4'hA);

        // Backpressure on channel 1
        out1_ready = 1'b0;
        drive(1, 1, 4'h3);
        cyc();
        drive(1, 1, 4'h5);
        #1;
        check("bp_rdy0", in_ready, 0);
        check("bp_d1", out1_data, 4'h3);
        cyc();
        check("bp_d1_hold", out1_data, 4'h3);
        out1_ready = 1'b1;
        #1;
        check("bp_rdy1", in_ready, 1);
        cyc();
        drive(0, 0, 4'h0);
        check("bp_v1", out1_valid, 1);
        check("bp_d1_new", out1_data, 4'h5);
        cyc();
        check("bp_v1_after", out1_valid, 0);
        check("bp_cnt1", cnt1, 2);

        // Isolation: channel 1 stalled while channel 0 streams
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("iso_clr0", cnt0, 0);
        check("iso_clr1", cnt1, 0);
        out1_ready = 1'b0;
        drive(1, 1, 4'hE);
        cyc();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, N'(i));
            #1;
            check("iso_rdy", in_ready, 1);
            cyc();
        end
        drive(0, 0, 4'h0);
        cyc();
        check("iso_cnt0", cnt0, 3);
        check("iso_cnt1", cnt1, 0);
        check("iso_v1", out1_valid, 1);
        check("iso_d1", out1_data, 4'hE);
        out1_ready = 1'b1;
        cyc();

        // Counter wrap after 256 deliveries, then clear vs increment
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, N'(i));
            cyc();
        end
        drive(0, 0, 4'h0);
        cyc();
        check("wrap_cnt0", cnt0, 0);
        drive(1, 0, 4'h6);
        cyc();
        drive(0, 0, 4'h0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clr_cnt0", cnt0, 0);
        check("clr_cnt1", cnt1, 0);
        check("clr_v0", out0_valid, 0);

        // Reset mid-stream with both channels full
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1, 0, 4'h7);
        cyc();
        drive(1, 1, 4'h9);
        cyc();
        drive(0, 0, 4'h0);
        check("mr_v0", out0_valid, 1);
        check("mr_v1", out1_valid, 1);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("mr_v0_rst", out0_valid, 0);
        check("mr_v1_rst", out1_valid, 0);
        check("mr_d0_rst", out0_data, 0);
        check("mr_d1_rst", out1_data, 0);
        check("mr_c0_rst", cnt0, 0);
        check("mr_c1_rst", cnt1, 0);
        in_select = 1'b0;
        #1;
        check("mr_rdy_s0", in_ready, 1);
        in_select = 1'b1;
        #1;
        check("mr_rdy_s1", in_ready, 1);

        // Random traffic
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom));
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 3) != 0);
            clear      = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk);
        #1;
        drive(0, 0, 4'h0);
        clear      = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (4) cyc();
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        check("drain_v0", out0_valid, 0);
        check("drain_v1", out1_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the data width in bits.
REQ-002 The block SHALL have parameter CW, default 8, giving the delivery-counter width in bits.
REQ-003 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  Reset, synchronous, active-low; SHALL be sampled on the rising edge of clk.
REQ-005 in_data  input  N  Input word.
REQ-006 in_select  input  1  Destination of the input word: 0 selects channel 0, 1 selects channel 1.
REQ-007 in_valid  input  1  Input word and select are valid.
REQ-008 in_ready  output  1  The block can accept the input word this cycle.
REQ-009 out0_data, out1_data  output  N each  Registered output words for channel 0 and channel 1.
REQ-010 out0_valid, out1_valid  output  1 each  The matching channel register holds a word.
REQ-011 out0_ready, out1_ready  input  1 each  The downstream side accepts the matching channel word.
REQ-012 clear  input  1  Synchronous zeroing of both delivery counters.
REQ-013 cnt0, cnt1  output  CW each  Completed deliveries on channel 0 and channel 1.

Function
REQ-014 Each channel SHALL have a one-entry output register with two states, EMPTY (outX_valid=0) and FULL (outX_valid=1).
REQ-015 in_ready SHALL be combinational and equal to (!outS_valid || outS_ready), where S = in_select; it SHALL NOT depend on in_valid.
REQ-016 An input accept occurs when in_valid=1 and in_ready=1 in the same cycle.
REQ-017 On an accept, the selected channel register SHALL load in_data on that edge, and its valid output SHALL be 1 in the next cycle (latency 1 cycle).
REQ-018 The unselected channel register SHALL be unaffected by an accept.
REQ-019 An output delivery on channel X occurs when outX_valid=1 and outX_ready=1.
REQ-020 On a delivery with no same-cycle load into channel X, channel X SHALL go FULL->EMPTY.
REQ-021 On a delivery with a same-cycle load into channel X, the register SHALL take the new word and outX_valid SHALL stay 1 (full throughput, no bubble).
REQ-022 While outX_valid=1 and outX_ready=0, outX_data SHALL stay stable and no load into channel X SHALL occur.
REQ-023 One channel may stall while the other keeps accepting and delivering; a stall on one channel SHALL NOT block words selected to the other.
REQ-024 Both channels may deliver in the same cycle.
REQ-025 Word order within each channel SHALL be preserved.
REQ-026 No word SHALL be dropped or duplicated.
REQ-027 outX_data SHALL retain its last value after a delivery; only outX_valid qualifies it.
REQ-028 cntX SHALL increment by 1 on each channel-X delivery and wrap modulo 2^CW (2^CW-1 -> 0).
REQ-029 When clear=1, both counters SHALL become 0 on that edge; clear SHALL take priority over a same-cycle increment.
REQ-030 in_select is don't-care when in_valid=0.

Reset
REQ-031 When rst_n=0 at a rising edge, the block SHALL set out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0 and cnt1=0.
REQ-032 A reset asserted mid-operation SHALL discard any buffered words; no delivery SHALL occur in the reset cycle.
REQ-033 Reset SHALL take priority over clear and over all handshakes.
REQ-034 While rst_n=0, in_ready SHALL still follow REQ-015; because both channels are EMPTY, it reads 1 from the first cycle after reset.

Verification
REQ-035 Route word 4'hA with in_select=0 and both readys=1 -> out0_valid=1 and out0_data=4'hA in the next cycle; out1_valid stays 0; cnt0=1 after the delivery.
REQ-036 Backpressure: out1_ready=0, send 4'h3 to channel 1, then present 4'h5 to channel 1 -> in_ready=0 and out1_data holds 4'h3; raise out1_ready -> 4'h3 is delivered, then 4'h5 is delivered, with no bubble.
REQ-037 Isolation: with channel 1 FULL and stalled, stream 4'h1, 4'h2, 4'h3 to channel 0 at one per cycle -> all three are delivered in order on channel 0, cnt0=3, and cnt1 is unchanged.
REQ-038 Counter wrap and clear: make 256 deliveries on channel 0 (CW=8) -> cnt0=0; assert clear in the same cycle as a delivery -> cnt0=0 and cnt1=0.
REQ-039 Reset mid-stream: with both channels FULL (4'h7, 4'h9), drive rst_n=0 for one cycle -> both valids=0, both data=0, both counters=0, and in_ready=1 afterwards.
REQ-040 Randomized 1000-cycle run with random valid, select, readys and data, checked against a scoreboard with two queues -> every word arrives on its selected channel, in order, exactly once.
